// File: rtl/corereset_seq_pkg.sv
// Package: corereset_seq_pkg
// Shared definitions for the multi-domain reset sequencer:
//   - sequencer FSM state encoding
//   - bit positions inside the sticky reset-cause register
//   - bit positions of the synchronised qualifier vector (all "1 = ok" polarity)
//   - small helper to size the shared FILTER/RELEASE counter
package corereset_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_QUAL,
        ST_FILTER,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int CAUSE_W    = 6;
    localparam int CAUSE_EXT  = 0;  // external reset pin
    localparam int CAUSE_POR  = 1;  // power-on reset or bank supply loss
    localparam int CAUSE_PLL  = 2;  // PLL lock lost
    localparam int CAUSE_INIT = 3;  // device init not done
    localparam int CAUSE_SSFF = 4;  // system services busy / flash-freeze restore
    localparam int CAUSE_SOFT = 5;  // per-channel soft reset

    localparam logic [CAUSE_W-1:0] CAUSE_RESET_VAL = 6'b000001;

    // Qualifier vector layout; every entry is converted to "1 = ok" before sync.
    localparam int NUM_QUAL = 7;
    localparam int Q_PLL    = 0;
    localparam int Q_INIT   = 1;
    localparam int Q_SS     = 2;
    localparam int Q_FF     = 3;
    localparam int Q_BX     = 4;
    localparam int Q_BY     = 5;
    localparam int Q_POR    = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/corereset_seq_pf_if.sv
// Interface: corereset_seq_pf_if
// Bundles the status qualifiers, soft-reset/cause-clear controls and the
// sequenced outputs of corereset_seq_pf.
//   slave  modport: used by the sequencer (qualifiers/controls in, resets out)
//   master modport: used by the environment driving the qualifiers
// Signals:
//   pll_lock, init_done, ss_busy, ff_us_restore,
//   bank_x_vddi_status, bank_y_vddi_status, fpga_por_n : async status inputs
//   soft_rst_req[N_OUT] : one-cycle synchronous soft-reset request per channel
//   cause_clr           : synchronous clear of rst_cause
//   fabric_reset_n[N_OUT], ready, rst_cause[6], pll_powerdown_b : outputs
interface corereset_seq_pf_if
    import corereset_seq_pkg::*;
#(
    parameter int N_OUT = 4
);
    logic                 pll_lock;
    logic                 init_done;
    logic                 ss_busy;
    logic                 ff_us_restore;
    logic                 bank_x_vddi_status;
    logic                 bank_y_vddi_status;
    logic                 fpga_por_n;
    logic [N_OUT-1:0]     soft_rst_req;
    logic                 cause_clr;
    logic [N_OUT-1:0]     fabric_reset_n;
    logic                 pll_powerdown_b;
    logic                 ready;
    logic [CAUSE_W-1:0]   rst_cause;

    modport slave (
        input  pll_lock, init_done, ss_busy, ff_us_restore,
               bank_x_vddi_status, bank_y_vddi_status, fpga_por_n,
               soft_rst_req, cause_clr,
        output fabric_reset_n, pll_powerdown_b, ready, rst_cause
    );

    modport master (
        output pll_lock, init_done, ss_busy, ff_us_restore,
               bank_x_vddi_status, bank_y_vddi_status, fpga_por_n,
               soft_rst_req, cause_clr,
        input  fabric_reset_n, pll_powerdown_b, ready, rst_cause
    );

endinterface

// File: rtl/corereset_sync.sv
// Module: corereset_sync
// STAGES-flop synchroniser with asynchronous active-low clear.
// Used as the reset bridge (d tied high: async assert, sync deassert) and as
// the synchroniser for each status qualifier (cleared to "not ok").
// Ports:
//   clk   in  clock
//   rst_n in  async active-low clear of all stages
//   d     in  asynchronous input
//   q     out synchronised output (last stage)
module corereset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/corereset_seq_pf.sv
// Module: corereset_seq_pf
// Multi-domain reset sequencer. Qualifies the external reset, PLL lock, init,
// system-services/flash-freeze status and bank supplies, then releases N_OUT
// active-low fabric resets in index order with STAGE_DLY cycles of spacing.
// Provides per-channel soft reset and a sticky reset-cause register.
// Ports:
//   clk        in  single clock
//   ext_rst_n  in  async active-low reset (async assert, sync deassert via bridge)
//   bus        slave modport of corereset_seq_pf_if (qualifiers, soft reset,
//              cause clear, fabric_reset_n, ready, rst_cause, pll_powerdown_b)
module corereset_seq_pf
    import corereset_seq_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16,
    parameter int STAGE_DLY   = 8,
    parameter int SOFT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 ext_rst_n,
    corereset_seq_pf_if.slave    bus
);

    localparam int CNT_W  = $clog2(max_int(FILT_CYCLES, STAGE_DLY)) + 1;
    localparam int SOFT_W = $clog2(SOFT_CYCLES) + 1;
    localparam int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    // ---------------------------------------------------------------
    // Reset bridge and qualifier synchronisers. The qualifier syncs are
    // cleared by the raw pin, not the bridge, so they are already settled
    // by the time the bridge lets the FSM run.
    // ---------------------------------------------------------------
    logic                rst_n_int;
    logic [NUM_QUAL-1:0] qual_raw;
    logic [NUM_QUAL-1:0] qual_sync;
    logic                qual_ok;

    corereset_sync #(.STAGES(SYNC_STAGES)) u_bridge (
        .clk   (clk),
        .rst_n (ext_rst_n),
        .d     (1'b1),
        .q     (rst_n_int)
    );

    always_comb begin
        qual_raw         = '0;
        qual_raw[Q_PLL]  = bus.pll_lock;
        qual_raw[Q_INIT] = bus.init_done;
        qual_raw[Q_SS]   = ~bus.ss_busy;
        qual_raw[Q_FF]   = ~bus.ff_us_restore;
        qual_raw[Q_BX]   = bus.bank_x_vddi_status;
        qual_raw[Q_BY]   = bus.bank_y_vddi_status;
        qual_raw[Q_POR]  = bus.fpga_por_n;
    end

    generate
        for (genvar gi = 0; gi < NUM_QUAL; gi++) begin : g_qual_sync
            corereset_sync #(.STAGES(SYNC_STAGES)) u_qsync (
                .clk   (clk),
                .rst_n (ext_rst_n),
                .d     (qual_raw[gi]),
                .q     (qual_sync[gi])
            );
        end
    endgenerate

    assign qual_ok = &qual_sync;

    // Cause bits to record when a qualifier drop forces a resequence.
    logic [CAUSE_W-1:0] loss_cause;

    always_comb begin
        loss_cause             = '0;
        loss_cause[CAUSE_POR]  = ~(qual_sync[Q_POR] & qual_sync[Q_BX] & qual_sync[Q_BY]);
        loss_cause[CAUSE_PLL]  = ~qual_sync[Q_PLL];
        loss_cause[CAUSE_INIT] = ~qual_sync[Q_INIT];
        loss_cause[CAUSE_SSFF] = ~(qual_sync[Q_SS] & qual_sync[Q_FF]);
    end

    // ---------------------------------------------------------------
    // Soft-reset request arbitration: lowest set index wins.
    // ---------------------------------------------------------------
    logic             soft_hit;
    logic [SEL_W-1:0] soft_pick;

    always_comb begin
        soft_hit  = 1'b0;
        soft_pick = '0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (bus.soft_rst_req[i]) begin
                soft_hit  = 1'b1;
                soft_pick = SEL_W'(i);
            end
        end
    end

    // ---------------------------------------------------------------
    // Sequencer state
    // ---------------------------------------------------------------
    state_t             state_reg,       state_next;
    logic [CNT_W-1:0]   cnt_reg,         cnt_next;
    logic [SEL_W-1:0]   rel_idx_reg,     rel_idx_next;
    logic [SEL_W-1:0]   rel_idx_inc;
    logic [N_OUT-1:0]   fabric_reg,      fabric_next;
    logic               ready_reg,       ready_next;
    logic [CAUSE_W-1:0] cause_reg,       cause_next;
    logic               soft_active_reg, soft_active_next;
    logic [SEL_W-1:0]   soft_idx_reg,    soft_idx_next;
    logic [SOFT_W-1:0]  soft_cnt_reg,    soft_cnt_next;

    assign rel_idx_inc = rel_idx_reg + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg       <= ST_RESET;
            cnt_reg         <= '0;
            rel_idx_reg     <= '0;
            fabric_reg      <= '0;
            ready_reg       <= 1'b0;
            cause_reg       <= CAUSE_RESET_VAL;
            soft_active_reg <= 1'b0;
            soft_idx_reg    <= '0;
            soft_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            rel_idx_reg     <= rel_idx_next;
            fabric_reg      <= fabric_next;
            ready_reg       <= ready_next;
            cause_reg       <= cause_next;
            soft_active_reg <= soft_active_next;
            soft_idx_reg    <= soft_idx_next;
            soft_cnt_reg    <= soft_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        rel_idx_next     = rel_idx_reg;
        fabric_next      = fabric_reg;
        ready_next       = ready_reg;
        soft_active_next = soft_active_reg;
        soft_idx_next    = soft_idx_reg;
        soft_cnt_next    = soft_cnt_reg;
        // Clear first so that any cause set below in the same cycle survives.
        cause_next       = bus.cause_clr ? '0 : cause_reg;

        case (state_reg)
            ST_RESET: begin
                state_next = ST_WAIT_QUAL;
            end

            ST_WAIT_QUAL: begin
                if (qual_ok) begin
                    state_next = ST_FILTER;
                    cnt_next   = '0;
                end
            end

            ST_FILTER: begin
                // Nothing has been released yet, so a drop here just restarts
                // the filter without recording a cause.
                if (!qual_ok) begin
                    state_next = ST_WAIT_QUAL;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(FILT_CYCLES - 1)) begin
                    cnt_next       = '0;
                    rel_idx_next   = '0;
                    fabric_next[0] = 1'b1;
                    if (N_OUT == 1) begin
                        state_next = ST_RUN;
                        ready_next = 1'b1;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!qual_ok) begin
                    state_next       = ST_WAIT_QUAL;
                    cnt_next         = '0;
                    fabric_next      = '0;
                    ready_next       = 1'b0;
                    soft_active_next = 1'b0;
                    cause_next       = cause_next | loss_cause;
                end else if (state_reg == ST_RELEASE) begin
                    if (cnt_reg == CNT_W'(STAGE_DLY - 1)) begin
                        cnt_next                 = '0;
                        rel_idx_next             = rel_idx_inc;
                        fabric_next[rel_idx_inc] = 1'b1;
                        if (rel_idx_reg == SEL_W'(N_OUT - 2)) begin
                            state_next = ST_RUN;
                            ready_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else if (soft_active_reg) begin
                    // Requests arriving while a soft reset runs are dropped.
                    if (soft_cnt_reg == SOFT_W'(SOFT_CYCLES - 1)) begin
                        fabric_next[soft_idx_reg] = 1'b1;
                        ready_next                = 1'b1;
                        soft_active_next          = 1'b0;
                    end else begin
                        soft_cnt_next = soft_cnt_reg + SOFT_W'(1);
                    end
                end else if (soft_hit) begin
                    soft_active_next       = 1'b1;
                    soft_idx_next          = soft_pick;
                    soft_cnt_next          = '0;
                    fabric_next[soft_pick] = 1'b0;
                    ready_next             = 1'b0;
                    cause_next[CAUSE_SOFT] = 1'b1;
                end
            end

            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    assign bus.fabric_reset_n  = fabric_reg;
    assign bus.ready           = ready_reg;
    assign bus.rst_cause       = cause_reg;
    assign bus.pll_powerdown_b = bus.fpga_por_n & bus.bank_x_vddi_status & bus.bank_y_vddi_status;

endmodule
